sd_cmd_phys_layer: RTL and testbench
====================================

# sd_cmd_phys_layer

SD-host CMD-line physical layer. It accepts a 40-bit command (start bit, transmission bit, 6-bit index, 32-bit argument) from the command controller through a strobe/ack handshake. It appends CRC7 and the end bit, and shifts the 48-bit frame out MSB-first on the bidirectional `cmd_pin`. It then releases the line, captures the card's 48-bit response and hands it back to the controller. It sits between the command controller and the SD pad, entirely in the `sd_clock` domain.

## Interface
Parameters:
- `FRAME_OUT`, 48: transmitted frame length in bits.
- `FRAME_IN`, 48: received response length in bits.
- `TIMEOUT`, 64: maximum `sd_clock` cycles waited for a response start bit.

Ports:
- `sd_clock` input 1: the only clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `strobe_in` input 1: controller requests transmission of `cmd_to_send`.
- `ack_in` input 1: controller acknowledges that the response was taken.
- `idle_in` input 1: abort; force IDLE.
- `cmd_to_send` input 40: {start, transmission, index[5:0], argument[31:0]}.
- `cmd_pin` inout 1: SD CMD line; driven during transmission, otherwise 1'bz.
- `response` output 48: captured response, MSB = first bit received.
- `strobe_out` output 1: response (or timeout) ready; held until `ack_in`.
- `ack_out` output 1: one-cycle pulse, command accepted.
- `timeout_err` output 1: valid with `strobe_out`; no start bit arrived within `TIMEOUT`.

## Operation
States: IDLE, LOAD, SEND, WAIT_RESP, RECEIVE, SEND_BACK.
- **IDLE:** `cmd_pin` = z. If `strobe_in`=1 and `idle_in`=0, go to LOAD.
- **LOAD:**
  - Compute CRC7 over `cmd_to_send` (polynomial x^7+x^3+1, init 0, MSB first).
  - Load shift register with {cmd_to_send, crc7, 1'b1}.
  - Pulse `ack_out`; clear `timeout_err`. Go to SEND.
- **SEND:**
  - Drive `cmd_pin` with shift-register MSB and shift left once per cycle.
  - After `FRAME_OUT` bits, release `cmd_pin` to z and go to WAIT_RESP.
- **WAIT_RESP:**
  - Count cycles; sample `cmd_pin` each cycle.
  - On a sampled 1'b0 (start bit), store it as `response[47]` and go to RECEIVE. A sampled z/x is treated as 1.
  - On count = `TIMEOUT`: set `timeout_err`, leave `response` unchanged, go to SEND_BACK.
- **RECEIVE:** Shift `cmd_pin` into `response` LSB-ward until `FRAME_IN` bits total have been captured, then go to SEND_BACK. The response CRC is not checked; the controller owns that.
- **SEND_BACK:** `strobe_out`=1. When `ack_in`=1, clear `strobe_out` and go to IDLE.
- **Abort:** `idle_in`=1 in any state forces IDLE on the next edge: `cmd_pin` z, `strobe_out`=0, counters cleared, `response` kept.
- **Priority:** `reset` > `idle_in` > normal transitions.
- `strobe_in` is ignored outside IDLE. A still-high `strobe_in` on return to IDLE starts a new command.
- **Bit counter:** counts 0..`FRAME_OUT`-1 (or `FRAME_IN`-1) and is cleared on every state entry. No wrap beyond frame length.

## Timing
- **Reset values:** state IDLE, `cmd_pin` z, `response` 0, `strobe_out` 0, `ack_out` 0, `timeout_err` 0, all counters 0.
- **Transmit:**
  - `strobe_in` sampled at edge N gives LOAD at N+1 (`ack_out` high during cycle N+1 only).
  - Bit 47 (start bit) is on `cmd_pin` from edge N+2.
  - The end bit is driven in cycle N+49; the line is z from edge N+50.
- **Turnaround:** WAIT_RESP begins at N+50. A start bit sampled at edge M gives `response` complete and `strobe_out` high from edge M+48.
- **Timeout:** `strobe_out` and `timeout_err` high `TIMEOUT` cycles after WAIT_RESP entry.
- **Ack:** `ack_in` sampled high at edge K gives `strobe_out` low and IDLE at K+1.
- The host never drives `cmd_pin` while the card may drive it.

## Test plan
- **CMD0:** reset 3 cycles, `cmd_to_send`=40'h4000000000, strobe_in pulse, card model silent.
  - `ack_out` pulses once.
  - `cmd_pin` serializes 48'h400000000095 MSB-first.
  - Line is z afterwards.
  - After 64 cycles, `strobe_out`=1 and `timeout_err`=1.
- **CMD8 with response:** `cmd_to_send`=40'h48000001AA.
  - Frame 48'h48000001AA87 is transmitted.
  - Card model answers 48'h08000001AA13 after 5 idle cycles.
  - `response`=48'h08000001AA13 and `strobe_out`=1, `timeout_err`=0.
- **Handshake hold:** keep `ack_in` low for 20 cycles -> `strobe_out` stays high and `response` stable. Assert `ack_in` -> `strobe_out` low on the next edge, state IDLE.
- **Abort mid-send:** assert `idle_in` at bit 20 of the transmission -> `cmd_pin` z on the next edge, `strobe_out` 0, and a new strobe is accepted afterwards.
- **Reset mid-receive:** assert `reset` during RECEIVE -> all outputs reach their reset values one edge later.
- **Back-to-back:** keep `strobe_in` high through `ack_in` -> a second identical frame starts 2 cycles after the return to IDLE.

Source files
------------

// File: rtl/sd_cmd_phys_layer.sv
// SD host CMD-line physical layer: frames a 40-bit command with CRC7 and end bit,
// shifts it out MSB-first, then captures the card response or flags a missing start bit.
module sd_cmd_phys_layer #(
  parameter int unsigned FRAME_OUT = 48,
  parameter int unsigned FRAME_IN  = 48,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                sd_clock,
  input  logic                reset,
  input  logic                strobe_in,
  input  logic                ack_in,
  input  logic                idle_in,
  input  logic [39:0]         cmd_to_send,
  inout  wire                 cmd_pin,
  output logic [FRAME_IN-1:0] response,
  output logic                strobe_out,
  output logic                ack_out,
  output logic                timeout_err
);

  localparam int unsigned CMD_W   = 40;
  localparam int unsigned CRC_W   = 7;
  localparam int unsigned TX_W    = CMD_W + CRC_W + 1;
  localparam int unsigned MAX_LEN = (FRAME_OUT > FRAME_IN) ? FRAME_OUT : FRAME_IN;
  localparam int unsigned MAX_CNT = (MAX_LEN > TIMEOUT) ? MAX_LEN : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_RESP,
    RECEIVE,
    SEND_BACK
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TX_W-1:0]      tx_q, tx_d;
  logic [FRAME_IN-1:0]  rx_q, rx_d;
  logic                 cmd_oe, oe_d;
  logic [FRAME_IN-1:0]  resp_d;
  logic                 strobe_d, ack_d, tout_d;
  logic                 rx_bit_c;

  // CRC7, polynomial x^7 + x^3 + 1, zero init, MSB first
  function automatic logic [CRC_W-1:0] crc7(input logic [CMD_W-1:0] data);
    logic [CRC_W-1:0] crc;
    logic             fb;
    crc = '0;
    for (int i = CMD_W - 1; i >= 0; i--) begin
      fb  = data[i] ^ crc[CRC_W-1];
      crc = {crc[CRC_W-2:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  assign cmd_pin = cmd_oe ? tx_q[TX_W-1] : 1'bz;

  // Anything other than a solid low on the line reads as idle-high
  always_comb begin
    rx_bit_c = 1'b1;
    if (cmd_pin == 1'b0) rx_bit_c = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    oe_d     = 1'b0;
    resp_d   = response;
    strobe_d = 1'b0;
    ack_d    = 1'b0;
    tout_d   = timeout_err;
    unique case (state_q)
      IDLE: begin
        if (strobe_in) begin
          state_d = LOAD;
          cnt_d   = '0;
          ack_d   = 1'b1;
          tout_d  = 1'b0;
        end
      end
      LOAD: begin
        tx_d    = {cmd_to_send, crc7(cmd_to_send), 1'b1};
        oe_d    = 1'b1;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (cnt_q == CNT_W'(FRAME_OUT - 1)) begin
          state_d = WAIT_RESP;
          cnt_d   = '0;
        end else begin
          oe_d  = 1'b1;
          tx_d  = {tx_q[TX_W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RESP: begin
        if (!rx_bit_c) begin
          rx_d    = {rx_q[FRAME_IN-2:0], 1'b0};
          cnt_d   = '0;
          state_d = RECEIVE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tout_d   = 1'b1;
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = SEND_BACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECEIVE: begin
        if (cnt_q == CNT_W'(FRAME_IN - 1)) begin
          resp_d   = rx_q;
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = SEND_BACK;
        end else begin
          rx_d  = {rx_q[FRAME_IN-2:0], rx_bit_c};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND_BACK: begin
        if (ack_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          strobe_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over every normal transition; the last response is kept
    if (idle_in) begin
      state_d  = IDLE;
      cnt_d    = '0;
      oe_d     = 1'b0;
      strobe_d = 1'b0;
      ack_d    = 1'b0;
      tout_d   = timeout_err;
    end
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cmd_oe      <= 1'b0;
      response    <= '0;
      strobe_out  <= 1'b0;
      ack_out     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cmd_oe      <= oe_d;
      response    <= resp_d;
      strobe_out  <= strobe_d;
      ack_out     <= ack_d;
      timeout_err <= tout_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_phys_layer.sv
// Bench for sd_cmd_phys_layer: command serialization, response capture, timeout,
// handshake hold, abort, reset and back-to-back commands, with a silent/answering card.
`timescale 1ns/1ps
module tb_sd_cmd_phys_layer;

  localparam int unsigned TIMEOUT = 64;
  localparam logic [39:0] CMD0     = 40'h4000000000;
  localparam logic [47:0] CMD0_FRM = 48'h400000000095;
  localparam logic [39:0] CMD8     = 40'h48000001AA;
  localparam logic [47:0] CMD8_FRM = 48'h48000001AA87;
  localparam logic [47:0] R7       = 48'h08000001AA13;

  logic        sd_clock = 1'b0;
  logic        reset, strobe_in, ack_in, idle_in;
  logic [39:0] cmd_to_send;
  wire         cmd_pin;
  logic [47:0] response;
  logic        strobe_out, ack_out, timeout_err;
  logic        card_oe, card_bit;

  int          checks = 0;
  int          errors = 0;
  logic [47:0] exp_tx_q[$];
  logic [47:0] exp_rx_q[$];

  // The card side: open line is pulled high like the real SD bus
  assign cmd_pin = card_oe ? card_bit : 1'bz;
  pullup (cmd_pin);

  always #5 sd_clock = ~sd_clock;

  sd_cmd_phys_layer #(.FRAME_OUT(48), .FRAME_IN(48), .TIMEOUT(TIMEOUT)) dut (
    .sd_clock    (sd_clock),
    .reset       (reset),
    .strobe_in   (strobe_in),
    .ack_in      (ack_in),
    .idle_in     (idle_in),
    .cmd_to_send (cmd_to_send),
    .cmd_pin     (cmd_pin),
    .response    (response),
    .strobe_out  (strobe_out),
    .ack_out     (ack_out),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(negedge sd_clock);
  endtask

  task automatic wait_ack_out(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      seen = (ack_out === 1'b1);
    end
  endtask

  task automatic capture_frame(output logic [47:0] f, output logic ack_first);
    f = '0;
    ack_first = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (i == 0) ack_first = ack_out;
      f = {f[46:0], cmd_pin};
    end
  endtask

  task automatic card_send(input logic [47:0] r);
    for (int i = 47; i >= 0; i--) begin
      card_oe  = 1'b1;
      card_bit = r[i];
      tick();
    end
    card_oe = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    while (strobe_out !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({strobe_out, ack_out, timeout_err} !== 3'b000 || response !== 48'h0) begin
      errors++;
      $display("FAIL reset_outputs got so=%b ao=%b te=%b resp=%h want 0 0 0 0",
               strobe_out, ack_out, timeout_err, response);
    end
    checks++;
    if (cmd_pin !== 1'b1) begin
      errors++;
      $display("FAIL reset_line got %b want released(1)", cmd_pin);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cmd0_timeout();
    bit seen; logic a1; logic [47:0] f, e; int n;
    cmd_to_send = CMD0;
    exp_tx_q.push_back(CMD0_FRM);
    exp_rx_q.push_back(48'h0);
    strobe_in = 1'b1;
    wait_ack_out(seen);
    strobe_in = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL cmd0_ack got none want pulse"); end
    capture_frame(f, a1);
    checks++;
    if (a1 !== 1'b0) begin errors++; $display("FAIL cmd0_ack_width got %b want 0", a1); end
    e = exp_tx_q.pop_front();
    checks++;
    if (f !== e) begin errors++; $display("FAIL cmd0_frame got %h want %h", f, e); end
    tick();
    checks++;
    if (cmd_pin !== 1'b1) begin errors++; $display("FAIL cmd0_release got %b want 1", cmd_pin); end
    wait_strobe(200, n);
    checks++;
    if (n != TIMEOUT) begin errors++; $display("FAIL cmd0_timeout_cycles got %0d want %0d", n, TIMEOUT); end
    e = exp_rx_q.pop_front();
    checks++;
    if (strobe_out !== 1'b1 || timeout_err !== 1'b1 || response !== e) begin
      errors++;
      $display("FAIL cmd0_timeout got so=%b te=%b resp=%h want 1 1 %h", strobe_out, timeout_err, response, e);
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++;
    if (strobe_out !== 1'b0) begin errors++; $display("FAIL cmd0_ack_in got so=%b want 0", strobe_out); end
    tick();
  endtask

  task automatic test_cmd8_response();
    bit seen; logic a1; logic [47:0] f, e; int n;
    cmd_to_send = CMD8;
    exp_tx_q.push_back(CMD8_FRM);
    exp_rx_q.push_back(R7);
    strobe_in = 1'b1;
    wait_ack_out(seen);
    strobe_in = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL cmd8_ack got none want pulse"); end
    capture_frame(f, a1);
    e = exp_tx_q.pop_front();
    checks++;
    if (f !== e) begin errors++; $display("FAIL cmd8_frame got %h want %h", f, e); end
    repeat (5) tick();
    card_send(R7);
    wait_strobe(10, n);
    checks++;
    if (n != 1) begin errors++; $display("FAIL cmd8_resp_latency got %0d want 1", n); end
    e = exp_rx_q.pop_front();
    checks++;
    if (response !== e || strobe_out !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL cmd8_response got resp=%h so=%b te=%b want %h 1 0", response, strobe_out, timeout_err, e);
    end
  endtask

  task automatic test_handshake_hold();
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (strobe_out !== 1'b1 || response !== R7) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++;
    if (strobe_out !== 1'b0) begin errors++; $display("FAIL hold_release got so=%b want 0", strobe_out); end
    tick();
  endtask

  task automatic test_abort_mid_send();
    bit seen; logic a1; logic [47:0] f, e, part; int n;
    cmd_to_send = CMD0;
    strobe_in = 1'b1;
    wait_ack_out(seen);
    strobe_in = 1'b0;
    part = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      part = {part[46:0], cmd_pin};
    end
    checks++;
    if (part[19:0] !== CMD0_FRM[47:28]) begin
      errors++;
      $display("FAIL abort_prefix got %h want %h", part[19:0], CMD0_FRM[47:28]);
    end
    idle_in = 1'b1;
    tick();
    idle_in = 1'b0;
    checks++;
    if (cmd_pin !== 1'b1 || strobe_out !== 1'b0 || ack_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got pin=%b so=%b ao=%b want 1 0 0", cmd_pin, strobe_out, ack_out);
    end
    // New command after the abort; card stays silent so it times out
    cmd_to_send = CMD8;
    exp_tx_q.push_back(CMD8_FRM);
    exp_rx_q.push_back(R7);
    strobe_in = 1'b1;
    wait_ack_out(seen);
    strobe_in = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_restart_ack got none want pulse"); end
    capture_frame(f, a1);
    e = exp_tx_q.pop_front();
    checks++;
    if (f !== e) begin errors++; $display("FAIL abort_restart_frame got %h want %h", f, e); end
    wait_strobe(200, n);
    e = exp_rx_q.pop_front();
    checks++;
    if (strobe_out !== 1'b1 || timeout_err !== 1'b1 || response !== e) begin
      errors++;
      $display("FAIL abort_restart_timeout got so=%b te=%b resp=%h want 1 1 %h", strobe_out, timeout_err, response, e);
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_receive();
    bit seen; logic a1; logic [47:0] f;
    cmd_to_send = CMD8;
    strobe_in = 1'b1;
    wait_ack_out(seen);
    strobe_in = 1'b0;
    capture_frame(f, a1);
    repeat (3) tick();
    for (int i = 47; i > 37; i--) begin
      card_oe  = 1'b1;
      card_bit = R7[i];
      tick();
    end
    card_oe = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({strobe_out, ack_out, timeout_err} !== 3'b000 || response !== 48'h0 || cmd_pin !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_rx got so=%b ao=%b te=%b resp=%h pin=%b want 0 0 0 0 1",
               strobe_out, ack_out, timeout_err, response, cmd_pin);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit seen; logic a1; logic [47:0] f, e; int n;
    cmd_to_send = CMD8;
    exp_tx_q.push_back(CMD8_FRM);
    exp_tx_q.push_back(CMD8_FRM);
    exp_rx_q.push_back(R7);
    exp_rx_q.push_back(R7);
    strobe_in = 1'b1;
    wait_ack_out(seen);
    capture_frame(f, a1);
    e = exp_tx_q.pop_front();
    checks++;
    if (f !== e) begin errors++; $display("FAIL b2b_frame1 got %h want %h", f, e); end
    repeat (5) tick();
    card_send(R7);
    wait_strobe(10, n);
    e = exp_rx_q.pop_front();
    checks++;
    if (response !== e || strobe_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_resp1 got resp=%h so=%b want %h 1", response, strobe_out, e);
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++;
    if (strobe_out !== 1'b0 || ack_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got so=%b ao=%b want 0 0", strobe_out, ack_out);
    end
    tick();
    strobe_in = 1'b0;
    checks++;
    if (ack_out !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got ao=%b want 1", ack_out); end
    capture_frame(f, a1);
    e = exp_tx_q.pop_front();
    checks++;
    if (f !== e) begin errors++; $display("FAIL b2b_frame2 got %h want %h", f, e); end
    wait_strobe(200, n);
    e = exp_rx_q.pop_front();
    checks++;
    if (strobe_out !== 1'b1 || timeout_err !== 1'b1 || response !== e) begin
      errors++;
      $display("FAIL b2b_timeout2 got so=%b te=%b resp=%h want 1 1 %h", strobe_out, timeout_err, response, e);
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    strobe_in   = 1'b0;
    ack_in      = 1'b0;
    idle_in     = 1'b0;
    cmd_to_send = '0;
    card_oe     = 1'b0;
    card_bit    = 1'b1;
    test_reset();
    test_cmd0_timeout();
    test_cmd8_response();
    test_handshake_hold();
    test_abort_mid_send();
    test_reset_mid_receive();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
